// File: rtl/cas_sort_sched.sv
// Sequential descending sorter: one compare-and-swap unit is time-shared and
// scheduled as an odd-even transposition sort, with valid/ready on both sides.
module cas_sort_sched #(
  parameter int SNG_WIDTH  = 8,
  parameter int NUM_INPUTS = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_INPUTS*SNG_WIDTH-1:0] in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_INPUTS*SNG_WIDTH-1:0] out_data,
  output logic [5:0]                      swap_cnt,
  output logic                            busy
);

  localparam int CW = 4;
  localparam logic [CW-1:0] N_C = CW'(NUM_INPUTS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SORT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [SNG_WIDTH-1:0] elem_q [NUM_INPUTS];
  logic [SNG_WIDTH-1:0] elem_d [NUM_INPUTS];
  logic [CW-1:0]        pass_q, pass_d;
  logic [CW-1:0]        j_q, j_d;
  logic [5:0]           swap_cnt_q;
  logic                 swap_s;
  logic                 last_s;
  logic [CW-1:0]        j_step_s, pass_inc_s, pass_par_s;

  // Borrow out of the widened subtraction flags a < b (unsigned).
  function automatic logic cas_borrow(input logic [SNG_WIDTH-1:0] a,
                                      input logic [SNG_WIDTH-1:0] b);
    logic [SNG_WIDTH:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return diff[SNG_WIDTH];
  endfunction

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_SORT);
  assign swap_cnt  = swap_cnt_q;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_pack
    assign out_data[SNG_WIDTH*g +: SNG_WIDTH] = elem_q[g];
  end

  always_comb begin
    elem_d = elem_q;
    swap_s = 1'b0;
    for (int i = 0; i < NUM_INPUTS - 1; i++) begin
      if ((j_q == CW'(i)) && cas_borrow(elem_q[i], elem_q[i+1])) begin
        elem_d[i]   = elem_q[i+1];
        elem_d[i+1] = elem_q[i];
        swap_s      = 1'b1;
      end else begin
        swap_s = swap_s;
      end
    end
  end

  // Pair scheduler; a pass with no legal pair (N=2, odd pass) is skipped outright.
  always_comb begin
    j_step_s   = j_q + 4'd2;
    pass_inc_s = pass_q + 4'd1;
    pass_par_s = {3'b000, pass_inc_s[0]};
    pass_d     = pass_q;
    j_d        = j_step_s;
    last_s     = 1'b0;
    if ((j_step_s + 4'd1) < N_C) begin
      pass_d = pass_q;
      j_d    = j_step_s;
      last_s = 1'b0;
    end else begin
      if ((pass_par_s + 4'd1) < N_C) begin
        pass_d = pass_inc_s;
        j_d    = pass_par_s;
      end else begin
        pass_d = pass_inc_s + 4'd1;
        j_d    = 4'd0;
      end
      last_s = (pass_d >= N_C);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pass_q     <= 4'd0;
      j_q        <= 4'd0;
      swap_cnt_q <= 6'd0;
      for (int i = 0; i < NUM_INPUTS; i++) elem_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < NUM_INPUTS; i++)
              elem_q[i] <= in_data[SNG_WIDTH*i +: SNG_WIDTH];
            pass_q     <= 4'd0;
            j_q        <= 4'd0;
            swap_cnt_q <= 6'd0;
            state_q    <= S_SORT;
          end
        end
        S_SORT: begin
          elem_q <= elem_d;
          pass_q <= pass_d;
          j_q    <= j_d;
          if (swap_s && (swap_cnt_q != 6'd63)) swap_cnt_q <= swap_cnt_q + 6'd1;
          if (last_s) state_q <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cas_sort_sched.sv
// Self-checking bench for cas_sort_sched at N=3 and N=8 against a
// sort-plus-inversion-count reference model.
module tb_cas_sort_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv3, ir3, ov3, or3, busy3;
  logic [23:0] id3, od3;
  logic [5:0]  sc3;
  logic        iv8, ir8, ov8, or8, busy8;
  logic [63:0] id8, od8;
  logic [5:0]  sc8;

  cas_sort_sched #(.SNG_WIDTH(8), .NUM_INPUTS(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .in_data(id3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3), .swap_cnt(sc3), .busy(busy3));

  cas_sort_sched #(.SNG_WIDTH(8), .NUM_INPUTS(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8), .swap_cnt(sc8), .busy(busy8));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [23:0] din;
    logic [23:0] dexp;
    logic [5:0]  sexp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: descending sort; adjacent stable swaps equal the strict inversion count.
  function automatic void ref_model(input logic [63:0] din, input int n,
                                    output logic [63:0] dout, output int swaps);
    int q[$];
    swaps = 0;
    for (int i = 0; i < n; i++) q.push_back(int'(din[8*i +: 8]));
    for (int i = 0; i < n; i++)
      for (int k = i + 1; k < n; k++)
        if (q[i] < q[k]) swaps++;
    q.rsort();
    dout = '0;
    for (int i = 0; i < n; i++) dout[8*i +: 8] = 8'(q[i]);
  endfunction

  function automatic logic [7:0] rv();
    int s;
    s = int'($urandom_range(0, 3));
    if (s == 0) return 8'd0;
    else if (s == 1) return 8'd255;
    else return 8'($urandom_range(0, 255));
  endfunction

  task automatic wait_ov3(output int lat);
    lat = 0;
    while (ov3 !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic run3(input logic [23:0] din, output logic [23:0] dout,
                      output logic [5:0] sw, output int lat);
    id3 = din; iv3 = 1'b1;
    @(posedge clk); #1;
    iv3 = 1'b0;
    wait_ov3(lat);
    dout = od3; sw = sc3;
    or3 = 1'b1;
    @(posedge clk); #1;
    or3 = 1'b0;
  endtask

  task automatic run8(input logic [63:0] din, output logic [63:0] dout,
                      output logic [5:0] sw, output int lat);
    id8 = din; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat = 0;
    while (ov8 !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    dout = od8; sw = sc8;
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
  endtask

  initial begin
    vec_t        tbl[5];
    logic [23:0] d3, e3;
    logic [63:0] d8, e8, r8;
    logic [5:0]  sw;
    int          lat, es;
    logic        pulsed;

    tbl[0] = '{24'h070905, 24'h050709, 6'd2};
    tbl[1] = '{24'h030201, 24'h010203, 6'd3};
    tbl[2] = '{24'h010203, 24'h010203, 6'd0};
    tbl[3] = '{24'hFF00FF, 24'h00FFFF, 6'd1};
    tbl[4] = '{24'h080808, 24'h080808, 6'd0};

    rst = 1'b1; iv3 = 1'b0; or3 = 1'b0; id3 = '0; iv8 = 1'b0; or8 = 1'b0; id8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready3", 64'(ir3), 64'd1);
    check("rst out_valid3", 64'(ov3), 64'd0);
    check("rst busy3", 64'(busy3), 64'd0);
    check("rst out_data3", 64'(od3), 64'd0);
    check("rst swap_cnt3", 64'(sc3), 64'd0);
    check("rst in_ready8", 64'(ir8), 64'd1);
    check("rst out_data8", od8, 64'd0);
    rst = 1'b0;

    // Directed table
    for (int t = 0; t < 5; t++) begin
      check("tbl in_ready", 64'(ir3), 64'd1);
      run3(tbl[t].din, d3, sw, lat);
      check("tbl data", 64'(d3), 64'(tbl[t].dexp));
      check("tbl swaps", 64'(sw), 64'(tbl[t].sexp));
      check("tbl latency", 64'(lat), 64'd3);
      check("tbl out_valid drop", 64'(ov3), 64'd0);
    end

    // Backpressure: hold out_ready low, offer a second vector meanwhile
    id3 = 24'h070905; iv3 = 1'b1;
    @(posedge clk); #1;
    id3 = 24'h020301;
    wait_ov3(lat);
    check("bp latency", 64'(lat), 64'd3);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp data stable", 64'(od3), 64'h050709);
      check("bp out_valid", 64'(ov3), 64'd1);
      check("bp in_ready", 64'(ir3), 64'd0);
      check("bp swaps stable", 64'(sc3), 64'd2);
    end
    or3 = 1'b1;
    @(posedge clk); #1;
    or3 = 1'b0;
    check("bp release out_valid", 64'(ov3), 64'd0);
    check("bp release in_ready", 64'(ir3), 64'd1);
    check("bp release busy", 64'(busy3), 64'd0);
    @(posedge clk); #1;
    iv3 = 1'b0;
    check("bp accept busy", 64'(busy3), 64'd1);
    check("bp accept in_ready", 64'(ir3), 64'd0);
    wait_ov3(lat);
    check("bp second latency", 64'(lat), 64'd3);
    check("bp second data", 64'(od3), 64'h010203);
    check("bp second swaps", 64'(sc3), 64'd2);
    or3 = 1'b1;
    @(posedge clk); #1;
    or3 = 1'b0;

    // Reset one cycle into SORT
    id3 = 24'h030201; iv3 = 1'b1;
    @(posedge clk); #1;
    iv3 = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid rst in_ready", 64'(ir3), 64'd1);
    check("mid rst busy", 64'(busy3), 64'd0);
    check("mid rst out_valid", 64'(ov3), 64'd0);
    check("mid rst out_data", 64'(od3), 64'd0);
    pulsed = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (ov3 !== 1'b0) pulsed = 1'b1;
    end
    check("mid rst no pulse", 64'(pulsed), 64'd0);
    run3(24'hFF00FF, d3, sw, lat);
    check("post rst data", 64'(d3), 64'h00FFFF);
    check("post rst swaps", 64'(sw), 64'd1);
    check("post rst latency", 64'(lat), 64'd3);

    // N=8 directed
    run8(64'h0706050403020100, d8, sw, lat);
    check("n8 data", d8, 64'h0001020304050607);
    check("n8 swaps", 64'(sw), 64'd28);
    check("n8 latency", 64'(lat), 64'd28);

    // N=8 random
    for (int v = 0; v < 1000; v++) begin
      r8 = '0;
      for (int i = 0; i < 8; i++) r8[8*i +: 8] = rv();
      ref_model(r8, 8, e8, es);
      run8(r8, d8, sw, lat);
      check("n8 rnd data", d8, e8);
      check("n8 rnd swaps", 64'(sw), 64'(es));
      check("n8 rnd latency", 64'(lat), 64'd28);
    end

    // N=3 random
    for (int v = 0; v < 300; v++) begin
      r8 = '0;
      for (int i = 0; i < 3; i++) r8[8*i +: 8] = rv();
      ref_model(r8, 3, e8, es);
      e3 = e8[23:0];
      run3(r8[23:0], d3, sw, lat);
      check("n3 rnd data", 64'(d3), 64'(e3));
      check("n3 rnd swaps", 64'(sw), 64'(es));
      check("n3 rnd latency", 64'(lat), 64'd3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cas_sort_sched.md
Name: cas_sort_sched

Overview:
- Sequential sorter that time-shares one compare-and-swap (CAS) unit to sort NUM_INPUTS unsigned SNG_WIDTH-bit values in descending order.
- Replaces the fully unrolled combinational CAS networks where area matters more than latency.
- Schedules comparisons as an odd-even transposition sort, one CAS per cycle, with valid/ready handshakes on input and output.
- Sits between the stochastic-number generators' binary sources and downstream consumers of sorted order (median/max selection).

Parameters:
- SNG_WIDTH, 8, bit width of each element.
- NUM_INPUTS, 3, number of elements; legal range 2..8.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input vector valid.
- in_ready  output  1  block can accept a vector.
- in_data  input  NUM_INPUTS*SNG_WIDTH  element i at bits [SNG_WIDTH*i +: SNG_WIDTH].
- out_valid  output  1  sorted vector available.
- out_ready  input  1  downstream accepts the vector.
- out_data  output  NUM_INPUTS*SNG_WIDTH  sorted vector; element 0 is the maximum; same packing as in_data.
- swap_cnt  output  6  number of swaps performed on the current or last vector.
- busy  output  1  high while in SORT.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State = IDLE.
  - in_ready = 1, out_valid = 0, busy = 0.
  - out_data = 0, swap_cnt = 0.
  - Pass and pair counters = 0.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready, register in_data into the element array, clear swap_cnt, set pass = 0 and pair index = 0, go to SORT.
  - SORT: in_ready = 0, busy = 1. Each cycle performs exactly one CAS on elements (j, j+1).
    - j starts at (pass mod 2) and steps by 2 while j+1 < NUM_INPUTS.
    - When the pass is exhausted, increment pass and restart j at the new parity.
    - When pass reaches NUM_INPUTS with its last pair processed, go to DONE. There is no early exit, so latency is fixed.
    - If a pass contains no legal pair (NUM_INPUTS = 2, odd pass), it is skipped with zero cycles spent.
  - DONE: out_valid = 1; out_data is driven from the element array. On out_ready, go to IDLE; out_valid drops on the following cycle.
- out_data, out_valid and swap_cnt are held stable while out_valid = 1 and out_ready = 0.
- CAS rule:
  - Compute the (SNG_WIDTH+1)-bit difference x[j] − x[j+1].
  - If its borrow bit (MSB) is 1, i.e. x[j] < x[j+1], swap the two elements and increment swap_cnt.
  - Equal values are not swapped, so the sort is stable.
  - Compare is unsigned; values 0 and 2^SNG_WIDTH−1 are handled correctly.
- Comparison count C:
  - C = sum over p = 0..NUM_INPUTS−1 of the number of pairs of parity p.
  - N=2 → 1, N=3 → 3, N=4 → 6, N=8 → 28.
- Latency:
  - Vector accepted at rising edge k gives out_valid = 1 after edge k+C.
  - Throughput is one vector per C+2 cycles, with zero backpressure.
- Handshake:
  - in_ready is combinationally 1 only in IDLE.
  - in_valid arriving while in SORT or DONE is ignored; the upstream holds it.
  - No bypass: a new vector cannot be accepted in the same cycle as an out handshake.
- Reset mid-operation: rst in any state returns all state and outputs to reset values on the next edge. The partially sorted data is discarded and out_valid never pulses.
- swap_cnt saturates at 63 (unreachable for N ≤ 8; maximum is 28).

Test Plan:
- N=3, in {5,9,7} (element 0 first) accepted at edge k → out_valid after edge k+3; out {9,7,5}; swap_cnt = 2.
- N=3, in {1,2,3} → out {3,2,1}, swap_cnt = 3. Then in {3,2,1} → out {3,2,1}, swap_cnt = 0, latency still 3.
- N=3, in {255,0,255} → out {255,255,0}; equal values not swapped. Also in {8,8,8} → swap_cnt = 0.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid → out_data stable, in_ready = 0, a new in_valid is not accepted. Release → IDLE, next vector accepted one cycle later.
- Reset mid-sort: assert rst one cycle into SORT → next cycle in_ready = 1, busy = 0, out_valid = 0, out_data = 0. A following vector sorts correctly.
- N=8 (parameter override), in {0,1,2,3,4,5,6,7} → out {7,6,5,4,3,2,1,0} after 28 cycles, swap_cnt = 28. 1000 random vectors must match a reference descending sort.
